problema1_column_scanner: RTL and testbench

//  Avalon-MM slave that drives an LED matrix by column multiplexing.

---
 rtl/problema1_column_scanner.sv | 194 +++++++++++++++++++
 tb/tb_problema1_column_scanner.sv | 269 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/problema1_column_scanner.sv
// Avalon-MM LED-matrix column scanner: frame buffer, one-hot column scan with blanking gap.
// Optional STATUS/irq logic is compiled in with `define COLUMN_SCANNER_IRQ_EN.
module problema1_column_scanner #(
  parameter int NUM_COLS     = 5,
  parameter int NUM_ROWS     = 7,
  parameter int DWELL_W      = 16,
  parameter int BLANK_CYCLES = 4
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [3:0]          address,
  input  logic                chipselect,
  input  logic                write_n,
  input  logic [31:0]         writedata,
  output logic [31:0]         readdata,
  output logic [NUM_COLS-1:0] col_out,
  output logic [NUM_ROWS-1:0] row_out,
  output logic                frame_done,
  output logic                irq
);

  localparam int CW = $clog2(NUM_COLS);
  localparam int BW = (BLANK_CYCLES > 1) ? $clog2(BLANK_CYCLES + 1) : 1;
  localparam logic [CW-1:0] LAST_COL   = CW'(NUM_COLS - 1);
  localparam logic [BW-1:0] BLANK_LOAD = BW'(BLANK_CYCLES);
  localparam bit            SKIP_BLANK = (BLANK_CYCLES == 0);

  typedef enum logic [1:0] {IDLE, BLANK, DRIVE} state_t;

  state_t               state, state_next;
  logic                 ctrl_en;
  logic [DWELL_W-1:0]   dwell;
  logic [DWELL_W-1:0]   dwell_cnt;
  logic [BW-1:0]        blank_cnt;
  logic [CW-1:0]        col_idx;
  logic [CW-1:0]        col_next_idx;
  logic [CW-1:0]        load_idx;
  logic [NUM_ROWS-1:0]  fb [NUM_COLS];
  logic                 wr;
  logic                 blank_load;
  logic                 drive_load;
  logic                 drive_exit;
  logic                 frame_end;
  logic [DWELL_W-1:0]   wd_dwell;
  logic                 unused_wdata;

  // Bus: a write is accepted in any cycle where chipselect & ~write_n is high;
  // there is no wait-request, so every access completes in that one cycle.
  assign wr           = chipselect & ~write_n;
  assign wd_dwell     = writedata[DWELL_W-1:0];
  assign unused_wdata = ^writedata;

  // ---------------- register file ----------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ctrl_en <= 1'b0;
      dwell   <= DWELL_W'(1000);
      for (int k = 0; k < NUM_COLS; k++) fb[k] <= '0;
    end else if (wr) begin
      if (address == 4'd0) ctrl_en <= writedata[0];
      if (address == 4'd1) dwell <= (wd_dwell == '0) ? DWELL_W'(1) : wd_dwell;
      for (int k = 0; k < NUM_COLS; k++)
        if (address == 4'(3 + k)) fb[k] <= writedata[NUM_ROWS-1:0];
    end
  end

  // ---------------- scan FSM: next state ----------------
  assign col_next_idx = (col_idx == LAST_COL) ? '0 : col_idx + CW'(1);
  // With no blanking the next column loads on the same edge the old one exits.
  assign load_idx     = drive_exit ? col_next_idx : col_idx;
  assign frame_end    = drive_exit && (col_idx == LAST_COL);

  always_comb begin
    state_next = state;
    blank_load = 1'b0;
    drive_load = 1'b0;
    drive_exit = 1'b0;
    if (!ctrl_en) begin
      state_next = IDLE;
    end else begin
      case (state)
        IDLE: begin
          if (SKIP_BLANK) begin
            state_next = DRIVE;
            drive_load = 1'b1;
          end else begin
            state_next = BLANK;
            blank_load = 1'b1;
          end
        end
        BLANK: begin
          if (blank_cnt <= BW'(1)) begin
            state_next = DRIVE;
            drive_load = 1'b1;
          end
        end
        DRIVE: begin
          if (dwell_cnt <= DWELL_W'(1)) begin
            drive_exit = 1'b1;
            if (SKIP_BLANK) begin
              state_next = DRIVE;
              drive_load = 1'b1;
            end else begin
              state_next = BLANK;
              blank_load = 1'b1;
            end
          end
        end
        default: state_next = IDLE;
      endcase
    end
  end

  // ---------------- scan FSM: state and datapath ----------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      col_idx    <= '0;
      dwell_cnt  <= '0;
      blank_cnt  <= '0;
      col_out    <= '0;
      row_out    <= '0;
      frame_done <= 1'b0;
    end else begin
      state      <= state_next;
      frame_done <= frame_end;
      if (!ctrl_en) begin
        col_idx   <= '0;
        dwell_cnt <= '0;
        blank_cnt <= '0;
        col_out   <= '0;
        row_out   <= '0;
      end else begin
        if (blank_load)          blank_cnt <= BLANK_LOAD;
        else if (state == BLANK) blank_cnt <= blank_cnt - BW'(1);
        if (drive_exit) begin
          col_idx <= col_next_idx;
          col_out <= '0;
          row_out <= '0;
        end
        // Row pattern is captured here and held; later FB writes wait for the next entry.
        if (drive_load) begin
          col_out   <= NUM_COLS'(1) << load_idx;
          row_out   <= fb[load_idx];
          dwell_cnt <= dwell;
        end else if (state == DRIVE) begin
          dwell_cnt <= dwell_cnt - DWELL_W'(1);
        end
      end
    end
  end

`ifdef COLUMN_SCANNER_IRQ_EN
  logic irq_en;
  logic status;
  logic irq_q;

  // A frame end in the same cycle as a software clear keeps the flag set.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      irq_en <= 1'b0;
      status <= 1'b0;
      irq_q  <= 1'b0;
    end else begin
      if (wr && address == 4'd0) irq_en <= writedata[1];
      if (frame_end)                                  status <= 1'b1;
      else if (wr && address == 4'd2 && writedata[0]) status <= 1'b0;
      irq_q <= status & irq_en;
    end
  end
  assign irq = irq_q;
`else
  assign irq = 1'b0;
`endif

  // ---------------- read mux ----------------
  always_comb begin
    readdata = '0;
    if (address == 4'd0) begin
      readdata[0]       = ctrl_en;
      readdata[8 +: CW] = col_idx;
`ifdef COLUMN_SCANNER_IRQ_EN
      readdata[1]       = irq_en;
`endif
    end
    if (address == 4'd1) readdata[DWELL_W-1:0] = dwell;
`ifdef COLUMN_SCANNER_IRQ_EN
    if (address == 4'd2) readdata[0] = status;
`endif
    for (int k = 0; k < NUM_COLS; k++)
      if (address == 4'(3 + k)) readdata[NUM_ROWS-1:0] = fb[k];
  end

endmodule

// File: tb/tb_problema1_column_scanner.sv
// Bench for problema1_column_scanner: register table, closed-form scan model, hand sequences.
// Two instances share the bus: BLANK_CYCLES=4 (dut_a) and BLANK_CYCLES=0 (dut_b).
module tb_problema1_column_scanner;

  localparam int N = 5;
  localparam int R = 7;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [3:0]  address = '0;
  logic        chipselect = 1'b0;
  logic        write_n = 1'b1;
  logic [31:0] writedata = '0;
  logic [31:0] rd_a, rd_b;
  logic [N-1:0] col_a, col_b;
  logic [R-1:0] row_a, row_b;
  logic        fd_a, fd_b, irq_a, irq_b;

  problema1_column_scanner #(.NUM_COLS(N), .NUM_ROWS(R), .DWELL_W(16), .BLANK_CYCLES(4)) dut_a (
    .clk(clk), .reset(reset), .address(address), .chipselect(chipselect), .write_n(write_n),
    .writedata(writedata), .readdata(rd_a), .col_out(col_a), .row_out(row_a),
    .frame_done(fd_a), .irq(irq_a));

  problema1_column_scanner #(.NUM_COLS(N), .NUM_ROWS(R), .DWELL_W(16), .BLANK_CYCLES(0)) dut_b (
    .clk(clk), .reset(reset), .address(address), .chipselect(chipselect), .write_n(write_n),
    .writedata(writedata), .readdata(rd_b), .col_out(col_b), .row_out(row_b),
    .frame_done(fd_b), .irq(irq_b));

  // ---------------- clock / cycle counter ----------------
  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- scoreboard ----------------
  int n_checks = 0;
  int n_pass = 0;
  int run_start = 0;
  logic [R-1:0] fb_m [N];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h (t=%0d)", name, act, exp, cyc - run_start);
  endtask

  // Closed-form view of the scan t edges after enable was written:
  // 1 idle cycle + b blank cycles, then columns of period d+b (d lit, b dark).
  function automatic logic [12:0] model(input int t, input int d, input int b);
    logic [4:0] c;
    logic [6:0] r;
    logic       f;
    int u, p, k, ph;
    c = '0; r = '0; f = 1'b0;
    if (t >= 1 + b) begin
      u = t - 1 - b;
      p = d + b;
      k = (u / p) % N;
      ph = u % p;
      if (ph < d) begin
        c = 5'(1 << k);
        r = fb_m[k];
      end
      if (u >= d && ((u - d) % p) == 0 && (((u - d) / p) % N) == N - 1) f = 1'b1;
    end
    return {f, r, c};
  endfunction

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic step_to(input int t);
    while (cyc - run_start < t) step();
  endtask

  task automatic bus_write(input logic [3:0] a, input logic [31:0] d);
    @(negedge clk);
    address = a; writedata = d; chipselect = 1'b1; write_n = 1'b0;
    @(posedge clk);
    #1;
    chipselect = 1'b0; write_n = 1'b1;
  endtask

  task automatic bus_read(input logic [3:0] a, output logic [31:0] da, output logic [31:0] db);
    @(negedge clk);
    address = a;
    #1;
    da = rd_a;
    db = rd_b;
  endtask

  task automatic load_fb();
    for (int k = 0; k < N; k++) bus_write(4'(3 + k), 32'(fb_m[k]));
  endtask

  task automatic run_model(input int d, input int cycles);
    logic [12:0] ea, eb;
    bus_write(4'd0, 32'd1);
    run_start = cyc;
    for (int i = 0; i < cycles; i++) begin
      step();
      ea = model(cyc - run_start, d, 4);
      eb = model(cyc - run_start, d, 0);
      check("scan_a", {19'd0, fd_a, row_a, col_a}, {19'd0, ea});
      check("scan_b", {19'd0, fd_b, row_b, col_b}, {19'd0, eb});
      check("onehot_b", 32'($countones(col_b)), 32'd1);
`ifndef COLUMN_SCANNER_IRQ_EN
      check("irq_tied", {31'd0, irq_a}, 32'd0);
`endif
    end
    bus_write(4'd0, 32'd0);
    step();
    check("off_a", {col_a, row_a}, '0);
    check("off_b", {col_b, row_b}, '0);
  endtask

  // ---------------- register table ----------------
  typedef struct {
    logic [3:0]  addr;
    logic        wr;
    logic [31:0] wdata;
    logic [31:0] exp;
  } reg_vec_t;

`ifdef COLUMN_SCANNER_IRQ_EN
  localparam logic [31:0] CTRL_IRQ_RB = 32'h2;
`else
  localparam logic [31:0] CTRL_IRQ_RB = 32'h0;
`endif

  initial begin
    reg_vec_t vecs [11];
    logic [31:0] ra, rb;
    int d;

    vecs[0]  = '{4'd0,  1'b0, 32'h0,          32'h0};
    vecs[1]  = '{4'd1,  1'b0, 32'h0,          32'd1000};
    vecs[2]  = '{4'd2,  1'b0, 32'h0,          32'h0};
    vecs[3]  = '{4'd1,  1'b1, 32'h0,          32'h1};
    vecs[4]  = '{4'd1,  1'b1, 32'h0001_2345,  32'h2345};
    vecs[5]  = '{4'd3,  1'b1, 32'hFFFF_FFAA,  32'h2A};
    vecs[6]  = '{4'd7,  1'b1, 32'h55,         32'h55};
    vecs[7]  = '{4'd8,  1'b1, 32'h12,         32'h0};
    vecs[8]  = '{4'd15, 1'b0, 32'h0,          32'h0};
    vecs[9]  = '{4'd2,  1'b1, 32'h1,          32'h0};
    vecs[10] = '{4'd0,  1'b1, 32'h2,          CTRL_IRQ_RB};

    // reset state
    #12;
    check("rst_col_a", 32'(col_a), 32'h0);
    check("rst_row_a", 32'(row_a), 32'h0);
    check("rst_fd_irq", {30'd0, fd_a, irq_a}, 32'h0);
    check("rst_b", {col_b, row_b, fd_b, irq_b}, '0);
    @(negedge clk);
    reset = 1'b0;

    for (int i = 0; i < 11; i++) begin
      if (vecs[i].wr) bus_write(vecs[i].addr, vecs[i].wdata);
      bus_read(vecs[i].addr, ra, rb);
      check($sformatf("reg_vec%0d", i), ra, vecs[i].exp);
    end

    // fixed pattern scan, two frames
    fb_m[0] = 7'h01; fb_m[1] = 7'h02; fb_m[2] = 7'h04; fb_m[3] = 7'h08; fb_m[4] = 7'h10;
    load_fb();
    bus_write(4'd1, 32'd3);
    run_model(3, 72);

    // row latch: rewrite col 2 while it is being driven
    bus_write(4'd0, 32'd1);
    run_start = cyc;
    step_to(19);
    check("latch_c2_entry", {col_a, row_a}, {5'b00100, 7'h04});
    bus_write(4'd5, 32'h7F);
    check("latch_hold0", {col_a, row_a}, {5'b00100, 7'h04});
    step_to(21);
    check("latch_hold1", {col_a, row_a}, {5'b00100, 7'h04});
    step_to(22);
    check("latch_exit", 32'(col_a), 32'h0);
    step_to(54);
    check("latch_next_frame", {col_a, row_a}, {5'b00100, 7'h7F});
    fb_m[2] = 7'h7F;

    // disable during col 3, then restart from col 0
    step_to(61);
    check("dis_c3", {col_a, row_a}, {5'b01000, 7'h08});
    bus_write(4'd0, 32'd0);
    step();
    check("dis_outputs", {col_a, row_a, fd_a}, '0);
    check("dis_outputs_b", {col_b, row_b}, '0);
    bus_read(4'd0, ra, rb);
    check("dis_col_idx", ra, 32'h0);
    bus_write(4'd0, 32'd1);
    run_start = cyc;
    step_to(4);
    check("restart_blank", 32'(col_a), 32'h0);
    step_to(5);
    check("restart_c0", {col_a, row_a}, {5'b00001, 7'h01});
    bus_read(4'd0, ra, rb);
    check("restart_ctrl", ra, 32'h1);
    bus_write(4'd0, 32'd0);
    step();

    // randomized frames; first pass uses DWELL written as 0 (1-cycle columns)
    for (int it = 0; it < 4; it++) begin
      d = (it == 0) ? 1 : int'($urandom_range(2, 6));
      bus_write(4'd1, (d == 1) ? 32'd0 : 32'(d));
      bus_read(4'd1, ra, rb);
      check("dwell_rb", ra, 32'(d));
      for (int k = 0; k < N; k++) fb_m[k] = 7'($urandom_range(0, 127));
      load_fb();
      run_model(d, 2 * N * (d + 4) + 4);
    end

`ifdef COLUMN_SCANNER_IRQ_EN
    // irq: set one cycle after frame_done, clear by write, set wins over clear
    bus_write(4'd1, 32'd0);
    bus_write(4'd0, 32'd3);
    run_start = cyc;
    step_to(26);
    check("irq_fd", {30'd0, fd_a, irq_a}, 32'h2);
    step_to(27);
    check("irq_set", 32'(irq_a), 32'h1);
    bus_read(4'd2, ra, rb);
    check("status_set", ra, 32'h1);
    bus_write(4'd2, 32'd1);
    step();
    check("irq_clear", 32'(irq_a), 32'h0);
    step_to(50);
    bus_write(4'd2, 32'd1);
    check("irq_race_fd", 32'(fd_a), 32'h1);
    step_to(52);
    check("irq_race_set", 32'(irq_a), 32'h1);
    bus_read(4'd2, ra, rb);
    check("status_race", ra, 32'h1);
    bus_write(4'd0, 32'd0);
    step();
`endif

    // asynchronous reset in the middle of a column
    bus_write(4'd1, 32'd10);
    bus_write(4'd0, 32'd1);
    run_start = cyc;
    step_to(7);
    check("pre_reset_drive", 32'(col_a), 32'h1);
    #2;
    reset = 1'b1;
    #1;
    check("async_rst_a", {col_a, row_a, fd_a}, '0);
    check("async_rst_b", {col_b, row_b}, '0);
    @(negedge clk);
    reset = 1'b0;
    bus_read(4'd0, ra, rb);
    check("rst_ctrl", ra, 32'h0);
    bus_read(4'd1, ra, rb);
    check("rst_dwell_a", ra, 32'd1000);
    check("rst_dwell_b", rb, 32'd1000);
    bus_read(4'd3, ra, rb);
    check("rst_fb0", ra, 32'h0);
    step();
    check("rst_stay_idle", {col_a, row_a}, '0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
